link_tx_arbiter: RTL and testbench

LINK_TX_ARBITER -- requirements
Module: link_tx_arbiter

---
 rtl/link_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_link_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_arbiter.sv
// Round-robin packet arbiter feeding a byte-framed serial link.
// Frames are 0x7E-delimited, and 0x7E/0x7D payload bytes are escaped as 0x7D, byte^0x20.
module link_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int PKT_SIZE = 32,
    localparam int PKT_BYTES = PKT_SIZE / 8,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW        = $clog2(PKT_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*PKT_SIZE-1:0] req_pkt,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      tx_en,
    output logic [7:0]                out_byte,
    output logic                      busy,
    output logic [GW-1:0]             grant_id
);

    localparam logic [7:0] FLAG = 8'h7E;
    localparam logic [7:0] ESCB = 8'h7D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ESC,
        S_END
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PKT_SIZE-1:0]   buf_q, buf_d;
    logic [7:0]            out_q, out_d;

    logic [PKT_SIZE-1:0]   pkt_arr [N_REQ];
    logic [7:0]            byte_arr [PKT_BYTES];
    logic [2*N_REQ-1:0]    dbl_valid;
    logic [N_REQ-1:0]      rot_valid;
    logic                  found;
    logic [GW-1:0]         win_idx;
    logic [GW-1:0]         ptr_after;
    logic [PKT_SIZE-1:0]   sel_pkt;
    logic [7:0]            cur_byte;
    logic                  last_byte;
    logic                  grant_now;
    int                    sum;

    // Requester i occupies req_pkt[i*PKT_SIZE +: PKT_SIZE]; byte 0 is the MSB byte.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pkt
        assign pkt_arr[gi] = req_pkt[gi*PKT_SIZE +: PKT_SIZE];
    end

    for (genvar gi = 0; gi < PKT_BYTES; gi++) begin : g_byte
        assign byte_arr[gi] = buf_q[PKT_SIZE-1-8*gi -: 8];
    end

    // Rotate requests so bit 0 is the pointer position, then take the first set bit.
    always_comb begin
        dbl_valid = {req_valid, req_valid};
        rot_valid = N_REQ'(dbl_valid >> ptr_q);
        found     = 1'b0;
        win_idx   = '0;
        sum       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && rot_valid[off]) begin
                found = 1'b1;
                sum   = int'(ptr_q) + off;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                win_idx = GW'(sum);
            end
        end
    end

    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                sel_pkt = pkt_arr[i];
            end
        end
        ptr_after = (win_idx == GW'(N_REQ - 1)) ? '0 : win_idx + GW'(1);
    end

    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < PKT_BYTES; k++) begin
            if (cnt_q == CW'(k)) begin
                cur_byte = byte_arr[k];
            end
        end
        last_byte = (cnt_q == CW'(PKT_BYTES - 1));
    end

    assign grant_now = rst_n && tx_en && (state_q == S_IDLE) && found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_now && (win_idx == GW'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        out_d   = out_q;
        if (tx_en) begin
            case (state_q)
                S_IDLE: begin
                    out_d = 8'h00;
                    cnt_d = '0;
                    if (found) begin
                        grant_d = win_idx;
                        buf_d   = sel_pkt;
                        ptr_d   = ptr_after;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    out_d   = FLAG;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (cur_byte == FLAG || cur_byte == ESCB) begin
                        out_d   = ESCB;
                        state_d = S_ESC;
                    end else begin
                        out_d   = cur_byte;
                        cnt_d   = cnt_q + CW'(1);
                        state_d = last_byte ? S_END : S_DATA;
                    end
                end
                S_ESC: begin
                    out_d   = cur_byte ^ 8'h20;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last_byte ? S_END : S_DATA;
                end
                S_END: begin
                    out_d   = FLAG;
                    state_d = S_IDLE;
                end
                default: begin
                    out_d   = 8'h00;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
        end
    end

    assign out_byte = out_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter: byte streams, grants and handshakes against hand-built frames,
// plus a frame decoder that recovers the packets from the captured stream.
module tb_link_tx_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_pkt;
    logic [3:0]   req_ready;
    logic         tx_en;
    logic [7:0]   out_byte;
    logic         busy;
    logic [1:0]   grant_id;

    int n_checks;
    int n_errors;

    logic [7:0]  cap_out[$];
    logic        cap_busy[$];
    logic [3:0]  cap_rr[$];
    logic [1:0]  cap_gid[$];
    logic        cap_en[$];
    logic [7:0]  exp_out[$];
    logic [31:0] sent_q[$];
    logic [31:0] tp[4];

    link_tx_arbiter #(.N_REQ(4), .PKT_SIZE(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .tx_en     (tx_en),
        .out_byte  (out_byte),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_cap();
        cap_out.delete();
        cap_busy.delete();
        cap_rr.delete();
        cap_gid.delete();
        cap_en.delete();
        exp_out.delete();
        sent_q.delete();
    endtask

    // One clock: sample the combinational handshake first, then the registered outputs after the edge.
    task automatic step();
        #1;
        cap_rr.push_back(req_ready);
        cap_en.push_back(tx_en);
        @(posedge clk);
        #1;
        cap_out.push_back(out_byte);
        cap_busy.push_back(busy);
        cap_gid.push_back(grant_id);
    endtask

    task automatic push_frame(input logic [31:0] pkt);
        logic [7:0] b;
        exp_out.push_back(8'h7E);
        for (int k = 0; k < 4; k++) begin
            b = pkt[31-8*k -: 8];
            if (b == 8'h7E || b == 8'h7D) begin
                exp_out.push_back(8'h7D);
                exp_out.push_back(b ^ 8'h20);
            end else begin
                exp_out.push_back(b);
            end
        end
        exp_out.push_back(8'h7E);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        check($sformatf("%s_len", tag), cap_out.size(), exp_out.size());
        n = (cap_out.size() < exp_out.size()) ? cap_out.size() : exp_out.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(cap_out[i]), 32'(exp_out[i]));
        end
    endtask

    // Receiver view: only bytes produced on enabled edges count.
    task automatic decode_check(input string tag);
        logic [31:0] acc;
        logic [31:0] rx[$];
        logic [7:0]  b;
        int          cnt;
        bit          in_f;
        bit          esc;
        int          n;
        acc = 0; cnt = 0; in_f = 0; esc = 0;
        for (int i = 0; i < cap_out.size(); i++) begin
            if (!cap_en[i]) continue;
            b = cap_out[i];
            if (b == 8'h7E) begin
                if (in_f && cnt > 0) begin
                    rx.push_back((cnt == 4) ? acc : (32'hBAD0_0000 | 32'(cnt)));
                    in_f = 0;
                end else begin
                    in_f = 1; cnt = 0; acc = 0; esc = 0;
                end
            end else if (in_f) begin
                if (b == 8'h7D && !esc) begin
                    esc = 1;
                end else begin
                    acc = {acc[23:0], (esc ? (b ^ 8'h20) : b)};
                    esc = 0;
                    cnt++;
                end
            end
        end
        check($sformatf("%s_rx_count", tag), rx.size(), sent_q.size());
        n = (rx.size() < sent_q.size()) ? rx.size() : sent_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_rx_pkt%0d", tag, i), rx[i], sent_q[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          first_flag;
        int          second_flag;
        int          ord;
        logic [3:0]  exp_rr;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        tx_en     = 1'b1;
        req_valid = 4'b0100;
        req_pkt   = '0;

        // Reset state, including a pending request that must not be acknowledged.
        #2;
        check("rst_out", 32'(out_byte), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, no escapes.
        clear_cap();
        req_pkt[31:0] = 32'h11223344;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        repeat (7) step();
        exp_out.push_back(8'h00);
        push_frame(32'h11223344);
        exp_out.push_back(8'h00);
        cmp_stream("t1");
        check("t1_ready_grant", 32'(cap_rr[0]), 32'h1);
        check("t1_ready_after", 32'(cap_rr[1]), 32'h0);
        check("t1_busy_start", 32'(cap_busy[0]), 32'h1);
        check("t1_busy_end", 32'(cap_busy[6]), 32'h0);
        check("t1_gid", 32'(cap_gid[0]), 32'h0);
        sent_q.push_back(32'h11223344);
        decode_check("t1");

        // Escaped bytes 0x7E and 0x7D.
        clear_cap();
        req_pkt[31:0] = 32'h7E7D1234;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        repeat (9) step();
        exp_out.push_back(8'h00);
        push_frame(32'h7E7D1234);
        exp_out.push_back(8'h00);
        cmp_stream("t2");
        first_flag = -1;
        second_flag = -1;
        for (int i = 0; i < cap_out.size(); i++) begin
            if (cap_out[i] == 8'h7E) begin
                if (first_flag < 0) first_flag = i;
                else if (second_flag < 0) second_flag = i;
            end
        end
        check("t2_frame_len", second_flag - first_flag + 1, 8);
        sent_q.push_back(32'h7E7D1234);
        decode_check("t2");

        // All four requesting: round-robin 0,1,2,3,0 with one idle byte between frames.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tp[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)};
            req_pkt[i*32 +: 32] = tp[i];
        end
        clear_cap();
        req_valid = 4'b1111;
        repeat (35) step();
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            exp_out.push_back(8'h00);
            push_frame(tp[k % 4]);
            sent_q.push_back(tp[k % 4]);
        end
        cmp_stream("t3");
        for (int j = 0; j < 35; j++) begin
            ord = (j / 7) % 4;
            exp_rr = ((j % 7) == 0) ? 4'(1 << ord) : 4'b0000;
            check($sformatf("t3_ready%0d", j), 32'(cap_rr[j]), 32'(exp_rr));
            check($sformatf("t3_busy%0d", j), 32'(cap_busy[j]), ((j % 7) != 6) ? 32'h1 : 32'h0);
            if ((j % 7) == 0) begin
                check($sformatf("t3_gid%0d", j), 32'(cap_gid[j]), 32'(ord));
            end
        end
        decode_check("t3");

        // Stall three cycles mid-DATA (pointer now 1, requester 1).
        clear_cap();
        req_pkt[63:32] = 32'h55667788;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        step();
        step();
        tx_en = 1'b0;
        repeat (3) step();
        tx_en = 1'b1;
        repeat (5) step();
        exp_out = '{8'h00, 8'h7E, 8'h55, 8'h55, 8'h55, 8'h55, 8'h66, 8'h77, 8'h88, 8'h7E, 8'h00};
        cmp_stream("t4");
        check("t4_busy_stall", 32'(cap_busy[4]), 32'h1);
        sent_q.push_back(32'h55667788);
        decode_check("t4");
        // Link disabled in IDLE: no handshake and no state change.
        tx_en = 1'b0;
        req_valid = 4'b0001;
        step();
        check("t4_idle_ready", 32'(cap_rr[cap_rr.size()-1]), 32'h0);
        check("t4_idle_busy", 32'(cap_busy[cap_busy.size()-1]), 32'h0);
        req_valid = 4'b0000;
        tx_en = 1'b1;

        // Reset mid-frame with requester 2 (pointer is 2), then requester 0 wins after release.
        clear_cap();
        req_pkt[95:64] = 32'hA1B2C3D4;
        req_pkt[31:0]  = 32'h0A0B0C0D;
        req_valid = 4'b0100;
        step();
        check("t5_ready2", 32'(cap_rr[0]), 32'h4);
        req_valid = 4'b0101;
        step();
        step();
        check("t5_midframe", 32'(cap_out[2]), 32'hA1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", 32'(out_byte), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        check("t5_rst_gid", 32'(grant_id), 32'h0);
        step();
        step();
        check("t5_rst_hold0", 32'(cap_out[3]), 32'h00);
        check("t5_rst_hold1", 32'(cap_out[4]), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        clear_cap();
        step();
        check("t5_ready0", 32'(cap_rr[0]), 32'h1);
        req_valid = 4'b0000;
        repeat (7) step();
        exp_out.push_back(8'h00);
        push_frame(32'h0A0B0C0D);
        exp_out.push_back(8'h00);
        cmp_stream("t5");
        sent_q.push_back(32'h0A0B0C0D);
        decode_check("t5");

        // Move pointer to 2 via requester 1, then only 1 and 3 request: 3 wins first.
        req_pkt[63:32]  = 32'h01020304;
        req_pkt[127:96] = 32'h0D0E0F10;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        repeat (6) step();
        clear_cap();
        req_valid = 4'b1010;
        repeat (14) step();
        req_valid = 4'b0000;
        check("t6_ready_first", 32'(cap_rr[0]), 32'h8);
        check("t6_ready_second", 32'(cap_rr[7]), 32'h2);
        check("t6_gid_first", 32'(cap_gid[0]), 32'h3);
        check("t6_gid_second", 32'(cap_gid[7]), 32'h1);
        sent_q.push_back(32'h0D0E0F10);
        sent_q.push_back(32'h01020304);
        decode_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
